vai_tx_sched: RTL and testbench
===============================

// Module: vai_tx_sched
// PURPOSE
//  Per-channel Tx scheduler for the VAI mux: shares one upstream CCI-P Tx channel among
//  N_REQ requesters (sub-AFUs plus manager AFU at index N_REQ-1) by round-robin arbitration,
//  with a per-requester rate quota enforced over a repeating cycle window. Drives the
//  one-hot select for the Tx mux datapath and the per-requester almFull back-pressure.
//  One instance per Tx channel (c0, c1).
// PARAMETERS
//  N_REQ     9   number of requesters (>=2); index N_REQ-1 is the manager, never quota-limited
//  CNT_W     16  width of quota, usage and window counters
// PORTS
//  clk           in   1             single clock
//  reset         in   1             synchronous, active-high
//  up_almFull    in   1             upstream almFull for this channel
//  req_valid     in   N_REQ         bit i: requester i presents a request this cycle
//  grant         out  N_REQ         one-hot grant, combinational from req_valid + registered state
//  grant_valid   out  1             OR of grant
//  grant_idx     out  $clog2(N_REQ) encoded index of grant (0 when grant_valid=0)
//  cfg_wr        in   1             write quota for requester cfg_idx
//  cfg_idx       in   $clog2(N_REQ) target requester
//  cfg_quota     in   CNT_W         max grants per window; 0 = unlimited
//  window_len    in   CNT_W         window length in cycles minus 1 (sampled at window wrap)
//  req_almFull   out  N_REQ         registered back-pressure to each requester
//  quota_hit     out  N_REQ         registered: requester i exhausted quota this window
// BEHAVIOUR
//  - Reset: all quotas 0 (unlimited), usage counters 0, window counter 0, rr pointer = N_REQ-1
//    (first search starts at 0), almFull_q=1, req_almFull all 1, quota_hit 0, grant forced 0.
//  - almFull_q <= up_almFull each cycle (1-cycle registered); all grants blocked while almFull_q=1.
//  - Eligible(i) = req_valid[i] & !almFull_q & (quota[i]==0 | used[i]<quota[i] | i==N_REQ-1).
//  - Arbitration: grant the first eligible index searching ptr+1, ptr+2, ... wrapping mod N_REQ;
//    at most one grant per cycle. On a grant, ptr <= granted index next cycle. No grant: ptr holds.
//  - A grant consumes exactly one request; requester holding req_valid is eligible again next
//    cycle, subject to rotation (lone requester may be granted every cycle).
//  - Usage: used[i] increments on grant[i]; saturates at all-ones; never wraps.
//  - Window: win_cnt counts up; when win_cnt==window_len_latched, next cycle win_cnt<=0,
//    window_len re-latched, all used[] cleared. Grant in the wrap cycle is counted in the
//    old window then cleared (not carried). window_len=0 => clear every cycle.
//  - cfg_wr: quota[cfg_idx] <= cfg_quota next cycle; used[] untouched. Lowering a quota below
//    used blocks that requester until window wrap. cfg_idx>=N_REQ ignored.
//  - Simultaneous cfg_wr and grant to same index: grant judged against old quota.
//  - quota_hit[i] <= (quota[i]!=0 & used_next[i]>=quota[i] & i!=N_REQ-1); cleared at wrap.
//  - req_almFull[i] <= almFull_q | quota_hit_next[i]  (2 cycles after up_almFull rises).
//    Requesters must tolerate the 2-cycle lag; downstream mux gates with grant, not almFull.
//  - reset asserted mid-operation: grant drops in the same cycle; all state to reset values
//    on the next edge; no partial window carried.
// TESTING
//  1 All N_REQ=9 req_valid=1, quotas 0, up_almFull=0: grants rotate 0,1,...,8,0 one per cycle
//    from the cycle after almFull_q clears; no index repeats within 9 cycles.
//  2 quota[2]=3, window_len=99, req_valid[2] only: grants on 3 consecutive cycles, then
//    quota_hit[2]=1, req_almFull[2]=1, no grant until cycle 100 wrap, then 3 grants again.
//  3 up_almFull pulse 1 cycle mid-stream: exactly one cycle with grant_valid=0, one cycle later;
//    req_almFull high for 1 cycle two cycles after the pulse.
//  4 quota all =1, window_len=0, req 3 and 8: alternating 3,8,3,8 (window clears each cycle);
//    manager (8) with quota 5 and window_len=999 still granted every alternate cycle.
//  5 cfg_wr quota[4]=2 while used[4]=5: requester 4 blocked immediately, resumes after wrap.
//  6 reset asserted while grants active: grant=0 that cycle; after release first grant is
//    index 0 when all requesting, req_almFull=1 for 2 cycles after reset deassert.

Source files
------------

// File: rtl/vai_tx_sched.sv
// vai_tx_sched: round-robin scheduler for one shared CCI-P Tx channel.
// Each requester lane tracks its own quota and usage, and the top module runs the arbiter and the quota window.
module vai_tx_sched_lane #(
  parameter int CNT_W  = 16,
  parameter bit IS_MGR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gnt_i,
  input  logic             wrap_i,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_quota_i,
  input  logic             almfull_i,
  output logic             quota_ok_o,
  output logic             quota_hit_o,
  output logic             req_almfull_o
);
  logic [CNT_W-1:0] quota_q, quota_d, used_q, used_d;
  logic             hit_d;

  // The arbiter checks eligibility against the quota currently in force.
  // quota_hit looks ahead to the quota that applies in the next cycle.
  assign quota_ok_o = IS_MGR || (quota_q == '0) || (used_q < quota_q);

  always_comb begin
    quota_d = cfg_we_i ? cfg_quota_i : quota_q;
    used_d  = used_q;
    if (wrap_i)
      used_d = '0;
    else if (gnt_i && (used_q != '1))
      used_d = used_q + 1'b1;
    hit_d = !IS_MGR && (quota_d != '0) && (used_d >= quota_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quota_q       <= '0;
      used_q        <= '0;
      quota_hit_o   <= 1'b0;
      req_almfull_o <= 1'b1;
    end else begin
      quota_q       <= quota_d;
      used_q        <= used_d;
      quota_hit_o   <= hit_d;
      req_almfull_o <= almfull_i | hit_d;
    end
  end
endmodule

module vai_tx_sched #(
  parameter  int N_REQ = 9,
  parameter  int CNT_W = 16,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_almFull,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  input  logic             cfg_wr,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [CNT_W-1:0] cfg_quota,
  input  logic [CNT_W-1:0] window_len,
  output logic [N_REQ-1:0] req_almFull,
  output logic [N_REQ-1:0] quota_hit
);
  logic             almFull_q;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] win_cnt_q, win_len_q;
  logic             wrap;
  logic [N_REQ-1:0] quota_ok, elig, cfg_we;
  logic             found;
  int               idx;

  // win_len_q comes out of reset at 0. The first window after reset therefore lasts one cycle,
  // and that cycle latches the live window_len.
  assign wrap = (win_cnt_q == win_len_q);
  assign elig = req_valid & quota_ok & {N_REQ{~almFull_q}};

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign cfg_we[i] = cfg_wr && (cfg_idx == IDX_W'(i));
    vai_tx_sched_lane #(.CNT_W(CNT_W), .IS_MGR(i == N_REQ-1)) u_lane (
      .clk          (clk),
      .reset        (reset),
      .gnt_i        (grant[i]),
      .wrap_i       (wrap),
      .cfg_we_i     (cfg_we[i]),
      .cfg_quota_i  (cfg_quota),
      .almfull_i    (almFull_q),
      .quota_ok_o   (quota_ok[i]),
      .quota_hit_o  (quota_hit[i]),
      .req_almfull_o(req_almFull[i])
    );
  end

  // Search rotates from ptr+1, and the current holder is checked last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    ptr_d     = ptr_q;
    found     = 1'b0;
    idx       = 0;
    if (!reset) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!found && elig[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IDX_W'(idx);
          ptr_d      = IDX_W'(idx);
        end
      end
    end
  end

  assign grant_valid = |grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      almFull_q <= 1'b1;
      ptr_q     <= IDX_W'(N_REQ-1);
      win_cnt_q <= '0;
      win_len_q <= '0;
    end else begin
      almFull_q <= up_almFull;
      ptr_q     <= ptr_d;
      if (wrap) begin
        win_cnt_q <= '0;
        win_len_q <= window_len;
      end else begin
        win_cnt_q <= win_cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vai_tx_sched.sv
// Bench for vai_tx_sched: directed scenarios plus random traffic, all checked against a cycle-level reference model.
module tb_vai_tx_sched;
  localparam int N = 9, CW = 16, IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset, up_almFull, cfg_wr, grant_valid;
  logic [N-1:0]  req_valid, grant, req_almFull, quota_hit;
  logic [IW-1:0] grant_idx, cfg_idx;
  logic [CW-1:0] cfg_quota, window_len;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  vai_tx_sched #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .up_almFull(up_almFull), .req_valid(req_valid),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_quota(cfg_quota), .window_len(window_len),
    .req_almFull(req_almFull), .quota_hit(quota_hit)
  );

  // Reference model state, kept as plain integers.
  int m_quota[N], m_used[N], m_win, m_wlen, m_ptr;
  bit m_alm;
  bit [N-1:0] m_hit, m_ralm;
  logic [N-1:0]  exp_grant;
  logic [IW-1:0] exp_idx;
  logic [31:0]   got_v, exp_v;

  function automatic void model_eval();
    exp_grant = '0;
    exp_idx   = '0;
    if (!reset && !m_alm)
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req_valid[c] && (c == N-1 || m_quota[c] == 0 || m_used[c] < m_quota[c])) begin
          exp_grant[c] = 1'b1;
          exp_idx = IW'(c);
          break;
        end
      end
    exp_v = {|exp_grant, exp_grant, exp_idx, m_ralm, m_hit};
    got_v = {grant_valid, grant, grant_idx, req_almFull, quota_hit};
  endfunction

  function automatic void model_adv();
    bit wrap;
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_quota[i] = 0; m_used[i] = 0; end
      m_win = 0; m_wlen = 0; m_ptr = N-1; m_alm = 1'b1; m_hit = '0; m_ralm = '1;
      return;
    end
    wrap = (m_win == m_wlen);
    if (cfg_wr && cfg_idx < N) m_quota[cfg_idx] = int'(cfg_quota);
    for (int i = 0; i < N; i++) begin
      if (wrap) m_used[i] = 0;
      else if (exp_grant[i] && m_used[i] < 65535) m_used[i]++;
      m_hit[i]  = (i != N-1) && m_quota[i] != 0 && m_used[i] >= m_quota[i];
      m_ralm[i] = m_alm | m_hit[i];
    end
    m_alm = up_almFull;
    if (exp_grant != '0) m_ptr = int'(exp_idx);
    if (wrap) begin m_win = 0; m_wlen = int'(window_len); end
    else m_win++;
  endfunction

  task automatic sample(); #1; model_eval(); endtask
  task automatic next_cyc(); model_adv(); @(negedge clk); endtask

  task automatic idle();
    cfg_wr = 0; cfg_idx = '0; cfg_quota = '0; up_almFull = 0; req_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1; req_valid = '0;
    sample(); next_cyc();
    sample(); next_cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    idle(); reset = 1; window_len = 16'd100; req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      sample();
      vecs++;
      if (got_v !== exp_v) begin errs++; $display("FAIL reset cyc %0d: got %h exp %h", c, got_v, exp_v); end
      vecs++;
      if (grant !== '0 || req_almFull !== '1 || quota_hit !== '0) begin
        errs++; $display("FAIL reset_vals cyc %0d: got g=%h ra=%h qh=%h exp g=0 ra=1ff qh=0", c, grant, req_almFull, quota_hit);
      end
      next_cyc();
    end
  endtask

  task automatic test_rotate();
    reset = 0;
    for (int c = 0; c < 12; c++) begin
      sample();
      vecs++;
      if (got_v !== exp_v) begin errs++; $display("FAIL rotate cyc %0d: got %h exp %h", c, got_v, exp_v); end
      vecs++;
      if (c == 0 ? grant_valid !== 1'b0 : (grant_valid !== 1'b1 || grant_idx !== IW'((c-1) % N))) begin
        errs++; $display("FAIL rotate_idx cyc %0d: got v=%b idx=%0d exp idx=%0d", c, grant_valid, grant_idx, (c-1) % N);
      end
      vecs++;
      if (req_almFull !== (c < 2 ? {N{1'b1}} : {N{1'b0}})) begin
        errs++; $display("FAIL rotate_almfull cyc %0d: got %h", c, req_almFull);
      end
      next_cyc();
    end
  endtask

  task automatic test_quota();
    idle(); window_len = 16'd99; do_reset();
    for (int c = 0; c < 111; c++) begin
      req_valid = 9'b1 << 2;
      cfg_wr = (c == 0); cfg_idx = 4'd2; cfg_quota = 16'd3;
      sample();
      vecs++;
      if (got_v !== exp_v) begin errs++; $display("FAIL quota cyc %0d: got %h exp %h", c, got_v, exp_v); end
      vecs++;
      if (grant_valid !== (c inside {1, 2, 3, 101, 102, 103})) begin
        errs++; $display("FAIL quota_grant cyc %0d: got %b", c, grant_valid);
      end
      if (c == 50 || c == 104) begin
        vecs++;
        if (quota_hit[2] !== 1'b1 || req_almFull[2] !== 1'b1) begin
          errs++; $display("FAIL quota_hit cyc %0d: got qh=%b ra=%b exp 1 1", c, quota_hit[2], req_almFull[2]);
        end
      end
      if (c == 102) begin
        vecs++;
        if (quota_hit[2] !== 1'b0) begin errs++; $display("FAIL quota_clear cyc %0d: got %b exp 0", c, quota_hit[2]); end
      end
      next_cyc();
    end
    cfg_wr = 0;
  endtask

  task automatic test_almfull();
    idle(); window_len = 16'd200; do_reset();
    for (int c = 0; c < 20; c++) begin
      req_valid = '1; up_almFull = (c == 10);
      sample();
      vecs++;
      if (got_v !== exp_v) begin errs++; $display("FAIL almfull cyc %0d: got %h exp %h", c, got_v, exp_v); end
      vecs++;
      if (grant_valid !== !(c == 0 || c == 11)) begin errs++; $display("FAIL almfull_gv cyc %0d: got %b", c, grant_valid); end
      vecs++;
      if (req_almFull !== ((c inside {0, 1, 12}) ? {N{1'b1}} : {N{1'b0}})) begin
        errs++; $display("FAIL almfull_ra cyc %0d: got %h", c, req_almFull);
      end
      next_cyc();
    end
    up_almFull = 0;
  endtask

  task automatic test_alt();
    int mgr_cnt = 0;
    idle(); window_len = 16'd0; do_reset();
    for (int c = 0; c < 60; c++) begin
      req_valid = 9'b1_0000_1000;
      cfg_wr = 0;
      if (c < 9)       begin cfg_wr = 1; cfg_idx = IW'(c); cfg_quota = 16'd1; end
      else if (c == 20) begin cfg_wr = 1; cfg_idx = 4'd8; cfg_quota = 16'd5; end
      else if (c == 21) begin cfg_wr = 1; cfg_idx = 4'd3; cfg_quota = 16'd0; end
      if (c >= 20) window_len = 16'd999;
      sample();
      vecs++;
      if (got_v !== exp_v) begin errs++; $display("FAIL alt cyc %0d: got %h exp %h", c, got_v, exp_v); end
      if (c >= 1) begin
        vecs++;
        if (grant_valid !== 1'b1 || grant_idx !== ((c % 2) ? 4'd3 : 4'd8)) begin
          errs++; $display("FAIL alt_idx cyc %0d: got v=%b idx=%0d exp %0d", c, grant_valid, grant_idx, (c % 2) ? 3 : 8);
        end
      end
      if (c >= 21 && grant[8] === 1'b1) mgr_cnt++;
      next_cyc();
    end
    cfg_wr = 0;
    vecs++;
    if (mgr_cnt != 19) begin errs++; $display("FAIL alt_mgr_count: got %0d exp 19", mgr_cnt); end
  endtask

  task automatic test_lower();
    idle(); window_len = 16'd50; do_reset();
    for (int c = 0; c < 60; c++) begin
      req_valid = 9'b1 << 4;
      cfg_wr = (c == 5); cfg_idx = 4'd4; cfg_quota = 16'd2;
      sample();
      vecs++;
      if (got_v !== exp_v) begin errs++; $display("FAIL lower cyc %0d: got %h exp %h", c, got_v, exp_v); end
      vecs++;
      if (grant_valid !== ((c >= 1 && c <= 5) || c == 52 || c == 53)) begin
        errs++; $display("FAIL lower_grant cyc %0d: got %b", c, grant_valid);
      end
      next_cyc();
    end
    cfg_wr = 0;
  endtask

  task automatic test_reset_mid();
    idle(); window_len = 16'd30; do_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid = '1;
      reset = (c == 5);
      sample();
      vecs++;
      if (got_v !== exp_v) begin errs++; $display("FAIL rstmid cyc %0d: got %h exp %h", c, got_v, exp_v); end
      if (c == 5) begin
        vecs++;
        if (grant !== '0) begin errs++; $display("FAIL rstmid_grant: got %h exp 0", grant); end
      end
      if (c == 7) begin
        vecs++;
        if (grant_valid !== 1'b1 || grant_idx !== '0) begin
          errs++; $display("FAIL rstmid_first: got v=%b idx=%0d exp 1 0", grant_valid, grant_idx);
        end
      end
      if (c >= 6) begin
        vecs++;
        if (req_almFull !== (c < 8 ? {N{1'b1}} : {N{1'b0}})) begin
          errs++; $display("FAIL rstmid_almfull cyc %0d: got %h", c, req_almFull);
        end
      end
      next_cyc();
    end
    reset = 0;
  endtask

  task automatic test_random();
    idle(); window_len = 16'd7; do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      req_valid  = N'($urandom);
      up_almFull = ($urandom_range(0, 9) == 0);
      cfg_wr     = ($urandom_range(0, 9) == 0);
      cfg_idx    = IW'($urandom_range(0, 15));
      cfg_quota  = CW'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) window_len = CW'($urandom_range(0, 15));
      sample();
      vecs++;
      if (got_v !== exp_v) begin errs++; $display("FAIL random cyc %0d: got %h exp %h", c, got_v, exp_v); end
      next_cyc();
    end
    idle(); reset = 0;
  endtask

  initial begin
    idle(); reset = 1; window_len = '0;
    model_adv();
    @(negedge clk);
    test_reset();
    test_rotate();
    test_quota();
    test_almfull();
    test_alt();
    test_lower();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
